// File: rtl/bp_dmi_to_axil_if.sv
// DMI request/response channel and AXI-Lite (32-bit data) bus bundles used by
// the DMI-to-AXI-Lite bridge.
interface bp_dmi_if;
   logic        req_valid;
   logic        req_ready;
   logic [6:0]  req_addr;
   logic [1:0]  req_op;
   logic [31:0] req_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_resp;

   modport master (output req_valid, req_addr, req_op, req_data, rsp_ready,
                   input  req_ready, rsp_valid, rsp_data, rsp_resp);
   modport slave  (input  req_valid, req_addr, req_op, req_data, rsp_ready,
                   output req_ready, rsp_valid, rsp_data, rsp_resp);
endinterface

interface bp_axil_if #(parameter int addr_width_p = 32);
   logic [addr_width_p-1:0] awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [31:0]             wdata;
   logic [3:0]              wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [addr_width_p-1:0] araddr;
   logic                    arvalid;
   logic                    arready;
   logic [31:0]             rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
                   input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid);
   modport slave  (input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
                   output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid);
endinterface

// File: rtl/bp_dmi_to_axil.sv
// DMI responder: each DMI request becomes one AXI-Lite read or write, one
// transaction in flight, response returned on the DMI rsp channel.
module bp_dmi_to_axil #(
   parameter int          axil_addr_width_p = 32,
   parameter logic [31:0] base_addr_p       = 32'h0000_0000
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   bp_dmi_if.slave   dmi,
   bp_axil_if.master axil
);
   typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_e;
   state_e state;

   logic [axil_addr_width_p-1:0] req_axil_addr;

   // DMI word address to byte address; the sum wraps at the AXI address width
   assign req_axil_addr = axil_addr_width_p'(base_addr_p + {23'b0, dmi.req_addr, 2'b00});
   assign dmi.req_ready = (state == IDLE);
   assign axil.wstrb    = 4'hF;

   // SLVERR/DECERR report failed, OKAY/EXOKAY report success
   function automatic logic [1:0] map_resp(input logic [1:0] r);
      return (r >= 2'd2) ? 2'd2 : 2'd0;
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state         <= IDLE;
         axil.awaddr   <= '0;
         axil.awvalid  <= 1'b0;
         axil.wdata    <= '0;
         axil.wvalid   <= 1'b0;
         axil.bready   <= 1'b0;
         axil.araddr   <= '0;
         axil.arvalid  <= 1'b0;
         axil.rready   <= 1'b0;
         dmi.rsp_valid <= 1'b0;
         dmi.rsp_data  <= '0;
         dmi.rsp_resp  <= '0;
      end else begin
         case (state)
            IDLE: if (dmi.req_valid) begin
               case (dmi.req_op)
                  2'd1: begin
                     axil.araddr  <= req_axil_addr;
                     axil.arvalid <= 1'b1;
                     state        <= RD_AR;
                  end
                  2'd2: begin
                     axil.awaddr  <= req_axil_addr;
                     axil.wdata   <= dmi.req_data;
                     axil.awvalid <= 1'b1;
                     axil.wvalid  <= 1'b1;
                     state        <= WR;
                  end
                  default: begin
                     dmi.rsp_data  <= '0;
                     dmi.rsp_resp  <= (dmi.req_op == 2'd3) ? 2'd2 : 2'd0;
                     dmi.rsp_valid <= 1'b1;
                     state         <= RSP;
                  end
               endcase
            end
            WR: begin
               if (axil.awready) axil.awvalid <= 1'b0;
               if (axil.wready)  axil.wvalid  <= 1'b0;
               if ((!axil.awvalid || axil.awready) && (!axil.wvalid || axil.wready)) begin
                  axil.bready <= 1'b1;
                  state       <= WR_B;
               end
            end
            WR_B: if (axil.bvalid) begin
               axil.bready   <= 1'b0;
               dmi.rsp_data  <= '0;
               dmi.rsp_resp  <= map_resp(axil.bresp);
               dmi.rsp_valid <= 1'b1;
               state         <= RSP;
            end
            RD_AR: if (axil.arready) begin
               axil.arvalid <= 1'b0;
               axil.rready  <= 1'b1;
               state        <= RD_R;
            end
            RD_R: if (axil.rvalid) begin
               axil.rready   <= 1'b0;
               dmi.rsp_data  <= axil.rdata;
               dmi.rsp_resp  <= map_resp(axil.rresp);
               dmi.rsp_valid <= 1'b1;
               state         <= RSP;
            end
            RSP: if (dmi.rsp_ready) begin
               dmi.rsp_valid <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bp_dmi_to_axil.sv
// Bench for bp_dmi_to_axil: directed vector table against a configurable AXI-Lite
// slave, plus reset-in-flight and address-wrap sequences.
module tb_bp_dmi_to_axil;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bp_dmi_if d ();
   bp_axil_if #(.addr_width_p(32)) a ();
   bp_dmi_if d2 ();
   bp_axil_if #(.addr_width_p(32)) a2 ();

   bp_dmi_to_axil #(.axil_addr_width_p(32), .base_addr_p(32'h0)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .dmi(d.slave), .axil(a.master));
   bp_dmi_to_axil #(.axil_addr_width_p(32), .base_addr_p(32'hFFFF_FFF0)) u_wrap (
      .clk_i(clk), .rst_ni(rst_n), .dmi(d2.slave), .axil(a2.master));

   // always-ready slave for the wrap instance
   assign a2.awready = 1'b1;
   assign a2.wready  = 1'b1;
   assign a2.bvalid  = 1'b1;
   assign a2.bresp   = 2'b00;
   assign a2.arready = 1'b1;
   assign a2.rvalid  = 1'b1;
   assign a2.rdata   = 32'hCAFE_0001;
   assign a2.rresp   = 2'b00;

   int tests = 0;
   int fails = 0;

   // slave configuration, set by the test before each transaction
   int aw_wait = 0, w_wait = 0, ar_wait = 0;
   logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   logic [31:0] rdata_cfg = '0;
   bit r_stall = 0;

   int aw_cnt, w_cnt, ar_cnt;
   logic aw_done, w_done;
   logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
   logic [3:0] cap_wstrb;
   int axi_cnt, early_cnt, viol;
   logic p_aw, p_w, p_ar;

   assign a.awready = a.awvalid && (aw_cnt >= aw_wait);
   assign a.wready  = a.wvalid && (w_cnt >= w_wait);
   assign a.arready = a.arvalid && (ar_cnt >= ar_wait);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
         aw_done <= 0; w_done <= 0;
         a.bvalid <= 0; a.bresp <= 0; a.rvalid <= 0; a.rdata <= 0; a.rresp <= 0;
         p_aw <= 0; p_w <= 0; p_ar <= 0;
      end else begin
         if (a.awvalid && a.awready) begin aw_cnt <= 0; cap_awaddr <= a.awaddr; end
         else if (a.awvalid) aw_cnt <= aw_cnt + 1;
         if (a.wvalid && a.wready) begin w_cnt <= 0; cap_wdata <= a.wdata; cap_wstrb <= a.wstrb; end
         else if (a.wvalid) w_cnt <= w_cnt + 1;
         if ((aw_done || (a.awvalid && a.awready)) && (w_done || (a.wvalid && a.wready))) begin
            aw_done <= 0; w_done <= 0;
            a.bvalid <= 1; a.bresp <= bresp_cfg;
         end else begin
            if (a.awvalid && a.awready) aw_done <= 1;
            if (a.wvalid && a.wready) w_done <= 1;
         end
         if (a.bvalid && a.bready) a.bvalid <= 0;
         if (a.arvalid && a.arready) begin
            ar_cnt <= 0; cap_araddr <= a.araddr;
            if (!r_stall) begin a.rvalid <= 1; a.rdata <= rdata_cfg; a.rresp <= rresp_cfg; end
         end else if (a.arvalid) ar_cnt <= ar_cnt + 1;
         if (a.rvalid && a.rready) a.rvalid <= 0;
         // a valid that was pending must still be high
         if ((p_aw && !a.awvalid) || (p_w && !a.wvalid) || (p_ar && !a.arvalid)) viol <= viol + 1;
         p_aw <= a.awvalid && !a.awready;
         p_w  <= a.wvalid && !a.wready;
         p_ar <= a.arvalid && !a.arready;
      end
   end

   always @(posedge clk) begin
      if (a.awvalid || a.wvalid || a.arvalid) axi_cnt <= axi_cnt + 1;
      if (a.wvalid && !a.awvalid) early_cnt <= early_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                      input int hold, output logic [31:0] rd, output logic [1:0] rr, output int lat);
      bit got, stable;
      @(negedge clk);
      d.req_valid = 1; d.req_op = op; d.req_addr = addr; d.req_data = data; d.rsp_ready = 0;
      for (int i = 0; i < 50 && !d.req_ready; i++) @(negedge clk);
      @(posedge clk);
      #1 d.req_valid = 0;
      lat = 0; got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk); lat++; got = d.rsp_valid;
      end
      check("rsp_arrives", 32'(got), 32'd1);
      rd = d.rsp_data; rr = d.rsp_resp; stable = 1;
      repeat (hold) begin
         @(negedge clk);
         if (!d.rsp_valid || d.rsp_data !== rd || d.rsp_resp !== rr) stable = 0;
      end
      if (hold > 0) check("rsp_held_stable", 32'(stable), 32'd1);
      d.rsp_ready = 1;
      @(posedge clk);
      #1 d.rsp_ready = 0;
      check("req_ready_after_rsp", 32'({d.req_ready, d.rsp_valid}), 32'b10);
   endtask

   typedef struct {
      logic [1:0] op; logic [6:0] addr; logic [31:0] data;
      int aw_w, w_w, ar_w; logic [1:0] bresp, rresp; logic [31:0] rdata; int hold;
      logic [31:0] exp_data; logic [1:0] exp_resp; int exp_lat; logic [31:0] exp_addr;
      bit exp_axi; bit exp_early;
   } vec_t;

   initial begin
      vec_t vecs[9];
      logic [31:0] rd;
      logic [1:0] rr;
      int lat, axi0, early0;
      bit got;

      vecs[0] = '{2'd2, 7'h10, 32'hDEAD_BEEF, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0, 32'h0, 2'd0, 3, 32'h40, 1, 0};
      vecs[1] = '{2'd1, 7'h11, 32'h0, 0, 0, 5, 2'b00, 2'b00, 32'h1234_5678, 0, 32'h1234_5678, 2'd0, 8, 32'h44, 1, 0};
      vecs[2] = '{2'd2, 7'h12, 32'h0BAD_F00D, 0, 4, 0, 2'b10, 2'b00, 32'h0, 3, 32'h0, 2'd2, 7, 32'h48, 1, 1};
      vecs[3] = '{2'd0, 7'h05, 32'h1111_1111, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0, 32'h0, 2'd0, 1, 32'h0, 0, 0};
      vecs[4] = '{2'd3, 7'h06, 32'h2222_2222, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0, 32'h0, 2'd2, 1, 32'h0, 0, 0};
      vecs[5] = '{2'd1, 7'h7F, 32'h0, 0, 0, 0, 2'b00, 2'b11, 32'hAAAA_5555, 0, 32'hAAAA_5555, 2'd2, 3, 32'h1FC, 1, 0};
      vecs[6] = '{2'd1, 7'h01, 32'h0, 0, 0, 0, 2'b00, 2'b01, 32'h0000_0F0F, 0, 32'h0000_0F0F, 2'd0, 3, 32'h4, 1, 0};
      vecs[7] = '{2'd2, 7'h00, 32'h8000_0001, 2, 0, 0, 2'b01, 2'b00, 32'h0, 0, 32'h0, 2'd0, 5, 32'h0, 1, 0};
      vecs[8] = '{2'd2, 7'h03, 32'hFFFF_FFFF, 0, 0, 0, 2'b11, 2'b00, 32'h0, 0, 32'h0, 2'd2, 3, 32'hC, 1, 0};

      d.req_valid = 0; d.req_op = 0; d.req_addr = 0; d.req_data = 0; d.rsp_ready = 0;
      d2.req_valid = 0; d2.req_op = 0; d2.req_addr = 0; d2.req_data = 0; d2.rsp_ready = 1;
      axi_cnt = 0; early_cnt = 0; viol = 0;

      repeat (3) @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      check("reset_state", 32'({d.req_ready, a.awvalid, a.wvalid, a.arvalid, a.bready, a.rready, d.rsp_valid}),
            32'b1000000);
      check("reset_rsp", 32'({d.rsp_data, d.rsp_resp}), 32'h0);

      foreach (vecs[k]) begin
         aw_wait = vecs[k].aw_w; w_wait = vecs[k].w_w; ar_wait = vecs[k].ar_w;
         bresp_cfg = vecs[k].bresp; rresp_cfg = vecs[k].rresp; rdata_cfg = vecs[k].rdata;
         axi0 = axi_cnt; early0 = early_cnt;
         txn(vecs[k].op, vecs[k].addr, vecs[k].data, vecs[k].hold, rd, rr, lat);
         check($sformatf("v%0d_data", k), rd, vecs[k].exp_data);
         check($sformatf("v%0d_resp", k), 32'(rr), 32'(vecs[k].exp_resp));
         check($sformatf("v%0d_latency", k), 32'(lat), 32'(vecs[k].exp_lat));
         check($sformatf("v%0d_axi_activity", k), 32'(axi_cnt != axi0), 32'(vecs[k].exp_axi));
         if (vecs[k].op == 2'd1) check($sformatf("v%0d_araddr", k), cap_araddr, vecs[k].exp_addr);
         if (vecs[k].op == 2'd2) begin
            check($sformatf("v%0d_awaddr", k), cap_awaddr, vecs[k].exp_addr);
            check($sformatf("v%0d_wdata", k), cap_wdata, vecs[k].data);
            check($sformatf("v%0d_wstrb", k), 32'(cap_wstrb), 32'hF);
            check($sformatf("v%0d_aw_first", k), 32'(early_cnt != early0), 32'(vecs[k].exp_early));
         end
      end

      // reset while waiting in RD_R, then a clean read
      aw_wait = 0; w_wait = 0; ar_wait = 0; rresp_cfg = 2'b00; r_stall = 1;
      @(negedge clk);
      d.req_valid = 1; d.req_op = 2'd1; d.req_addr = 7'h02;
      @(posedge clk);
      #1 d.req_valid = 0;
      for (int i = 0; i < 20 && !a.rready; i++) @(negedge clk);
      check("in_rd_r", 32'(a.rready), 32'd1);
      #1 rst_n = 0;
      #1;
      check("async_reset_drop", 32'({d.req_ready, a.arvalid, a.rready, a.awvalid, a.wvalid, d.rsp_valid}),
            32'b100000);
      @(negedge clk);
      rst_n = 1; r_stall = 0; rdata_cfg = 32'h5A5A_0008;
      txn(2'd1, 7'h08, 32'h0, 0, rd, rr, lat);
      check("post_reset_rdata", rd, 32'h5A5A_0008);
      check("post_reset_resp", 32'(rr), 32'd0);
      check("post_reset_araddr", cap_araddr, 32'h20);
      check("post_reset_latency", 32'(lat), 32'd3);

      // base 0xFFFF_FFF0 + 0x20 wraps to 0x10
      @(negedge clk);
      d2.req_valid = 1; d2.req_op = 2'd1; d2.req_addr = 7'h08;
      @(posedge clk);
      #1 d2.req_valid = 0;
      check("wrap_arvalid", 32'(a2.arvalid), 32'd1);
      check("wrap_araddr", a2.araddr, 32'h10);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = d2.rsp_valid; end
      check("wrap_rsp", 32'(got), 32'd1);
      check("wrap_rdata", d2.rsp_data, 32'hCAFE_0001);

      check("valid_dropped_early", 32'(viol), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
